// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and helpers for the forwarding / load-use hazard unit.
//   fwd_entry_t : one in-flight writer {valid, rd, load}; rd is zero-extended to FWD_RD_W
//   FWD_RF      : bypass select value meaning "read the register file"
//   sel_width() : width of one bypass select for a given number of tracked stages
package fwd_pkg;
    localparam int FWD_RD_W = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic [FWD_RD_W-1:0] rd;
        logic                load;
    } fwd_entry_t;

    function automatic int sel_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction
endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority scan of the shadow pipeline for one EX source operand.
//   ents    : in-flight writers, index 0 = MEM (youngest)
//   src     : source register address, used: operand is actually read
//   hit     : some stage matches; stage: youngest matching stage; is_load: that writer is a load
module fwd_match
    import fwd_pkg::*;
#(
    parameter int RAW   = 5,
    parameter int DEPTH = 2,
    parameter int SW    = 2
) (
    input  fwd_entry_t [DEPTH-1:0] ents,
    input  logic [RAW-1:0]         src,
    input  logic                   used,
    output logic                   hit,
    output logic [SW-1:0]          stage,
    output logic                   is_load
);
    always_comb begin
        hit     = 1'b0;
        stage   = '0;
        is_load = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites older ones.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && src != '0 && ents[k].valid && ents[k].rd == FWD_RD_W'(src)) begin
                hit     = 1'b1;
                stage   = SW'(k);
                is_load = ents[k].load;
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select, load-use stall and event counters.
//   CLK, nRST (async active-low)   : clock / reset
//   pipe_en, flush                 : pipeline advance, EX squash
//   ex_regwr, ex_load, ex_rd       : EX instruction's write info
//   ex_src, ex_src_used            : EX source operands (operand i at [i*RAW +: RAW])
//   fwd_sel                        : per-operand bypass (0 = regfile, k = stage k-1)
//   stall                          : load-use hazard
//   fwd_cnt, stall_cnt             : saturating event counters
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NSRC       = 2,
    parameter int RAW        = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 32,
    localparam int SW        = sel_width(DEPTH)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                pipe_en,
    input  logic                flush,
    input  logic                ex_regwr,
    input  logic                ex_load,
    input  logic [RAW-1:0]      ex_rd,
    input  logic [NSRC*RAW-1:0] ex_src,
    input  logic [NSRC-1:0]     ex_src_used,
    output logic [NSRC*SW-1:0]  fwd_sel,
    output logic                stall,
    output logic [CNT_W-1:0]    fwd_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);
    fwd_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [CNT_W-1:0]       fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0]        hit, ld;
    logic [SW-1:0]          stg [NSRC];

    for (genvar i = 0; i < NSRC; i++) begin : g_match
        fwd_match #(.RAW(RAW), .DEPTH(DEPTH), .SW(SW)) u_match (
            .ents    (ent_q),
            .src     (ex_src[i*RAW +: RAW]),
            .used    (ex_src_used[i]),
            .hit     (hit[i]),
            .stage   (stg[i]),
            .is_load (ld[i])
        );
    end

    always_comb begin
        stall   = 1'b0;
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++)
            if (hit[i] && ld[i] && int'(stg[i]) < LOAD_STAGE) stall = 1'b1;
        // A stall discards EX this cycle, so no operand is bypassed.
        for (int i = 0; i < NSRC; i++)
            fwd_sel[i*SW +: SW] = (stall || !hit[i]) ? SW'(FWD_RF) : stg[i] + SW'(1);
    end

    always_comb begin
        ent_d       = ent_q;
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pipe_en) begin
            for (int k = DEPTH - 1; k > 0; k--) ent_d[k] = ent_q[k-1];
            ent_d[0].valid = ex_regwr && !flush && !stall && ex_rd != '0;
            ent_d[0].rd    = FWD_RD_W'(ex_rd);
            ent_d[0].load  = ex_load;
            fwd_cnt_d   = (|fwd_sel && !(&fwd_cnt_q)) ? fwd_cnt_q + CNT_W'(1) : fwd_cnt_q;
            stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ent_q       <= '0;
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: random + directed check of two configurations against a behavioural model.
module tb_fwd_hazard_unit;
    logic        CLK = 1'b0, nRST = 1'b0;
    logic        pipe_en = 0, flush = 0, ex_regwr = 0, ex_load = 0;
    logic [4:0]  ex_rd = '0;
    logic [9:0]  ex_src = '0;
    logic [1:0]  ex_src_used = '0;
    logic [3:0]  fwd_sel_a, fwd_sel_b;
    logic        stall_a, stall_b;
    logic [31:0] fwd_cnt_a, stall_cnt_a;
    logic [3:0]  fwd_cnt_b, stall_cnt_b;
    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    fwd_hazard_unit u_a (
        .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .flush(flush), .ex_regwr(ex_regwr),
        .ex_load(ex_load), .ex_rd(ex_rd), .ex_src(ex_src), .ex_src_used(ex_src_used),
        .fwd_sel(fwd_sel_a), .stall(stall_a), .fwd_cnt(fwd_cnt_a), .stall_cnt(stall_cnt_a)
    );

    fwd_hazard_unit #(.DEPTH(3), .LOAD_STAGE(2), .CNT_W(4)) u_b (
        .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .flush(flush), .ex_regwr(ex_regwr),
        .ex_load(ex_load), .ex_rd(ex_rd), .ex_src(ex_src), .ex_src_used(ex_src_used),
        .fwd_sel(fwd_sel_b), .stall(stall_b), .fwd_cnt(fwd_cnt_b), .stall_cnt(stall_cnt_b)
    );

    // Model: list of in-flight writers per configuration, youngest first.
    int     dep[2]  = '{2, 3};
    int     lst[2]  = '{1, 2};
    longint cmax[2] = '{64'hffffffff, 64'd15};
    bit     mv[2][3];
    int     mrd[2][3];
    bit     mld[2][3];
    longint mfc[2], msc[2];

    task automatic expect_out(input int u, output logic [3:0] sel, output logic st);
        int win[2];
        st  = 0;
        sel = '0;
        for (int i = 0; i < 2; i++) begin
            int s;
            s = int'(ex_src[i*5 +: 5]);
            win[i] = -1;
            if (ex_src_used[i] && s != 0)
                for (int k = 0; k < dep[u]; k++)
                    if (win[i] < 0 && mv[u][k] && mrd[u][k] == s) win[i] = k;
            if (win[i] >= 0 && mld[u][win[i]] && win[i] < lst[u]) st = 1;
        end
        for (int i = 0; i < 2; i++)
            if (!st && win[i] >= 0) sel[i*2 +: 2] = 2'(win[i] + 1);
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int u = 0; u < 2; u++) begin
                mfc[u] = 0;
                msc[u] = 0;
                for (int k = 0; k < 3; k++) mv[u][k] = 0;
            end
        end else if (pipe_en) begin
            for (int u = 0; u < 2; u++) begin
                logic [3:0] sel;
                logic       st;
                expect_out(u, sel, st);
                if (sel != 0 && mfc[u] < cmax[u]) mfc[u]++;
                if (st && msc[u] < cmax[u]) msc[u]++;
                for (int k = dep[u] - 1; k > 0; k--) begin
                    mv[u][k]  = mv[u][k-1];
                    mrd[u][k] = mrd[u][k-1];
                    mld[u][k] = mld[u][k-1];
                end
                mv[u][0]  = ex_regwr && !flush && !st && ex_rd != 0;
                mrd[u][0] = int'(ex_rd);
                mld[u][0] = ex_load;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic [3:0] sel;
        logic       st;
        expect_out(0, sel, st);
        chk("model_sel_a", fwd_sel_a, sel);
        chk("model_stall_a", stall_a, st);
        chk("model_fcnt_a", fwd_cnt_a, mfc[0]);
        chk("model_scnt_a", stall_cnt_a, msc[0]);
        expect_out(1, sel, st);
        chk("model_sel_b", fwd_sel_b, sel);
        chk("model_stall_b", stall_b, st);
        chk("model_fcnt_b", fwd_cnt_b, mfc[1]);
        chk("model_scnt_b", stall_cnt_b, msc[1]);
    end

    task automatic drive(input bit pe, input bit fl, input bit rw, input bit ld,
                         input int rd, input int s0, input int s1, input bit [1:0] used);
        pipe_en     = pe;
        flush       = fl;
        ex_regwr    = rw;
        ex_load     = ld;
        ex_rd       = 5'(rd);
        ex_src      = {5'(s1), 5'(s0)};
        ex_src_used = used;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        longint fc, sc;
        #1;
        chk("reset_sel", fwd_sel_a, 0);
        chk("reset_stall", stall_a, 0);
        chk("reset_cnt", fwd_cnt_a + stall_cnt_a, 0);
        #13 nRST = 1'b1;
        tick();
        // simple EX->MEM forward
        drive(1, 0, 1, 0, 3, 1, 2, 2'b11); tick();
        drive(1, 0, 0, 0, 0, 3, 4, 2'b11); #2;
        chk("fwd_mem_sel0", fwd_sel_a[1:0], 1);
        chk("fwd_mem_sel1", fwd_sel_a[3:2], 0);
        chk("fwd_mem_stall", stall_a, 0);
        tick();
        chk("fwd_cnt_one", fwd_cnt_a, 1);
        // writer two stages ahead, then youngest-wins
        drive(1, 0, 1, 0, 5, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00); tick();
        drive(0, 0, 0, 0, 0, 0, 5, 2'b10); #2;
        chk("fwd_wb_sel1", fwd_sel_a[3:2], 2);
        tick();
        drive(1, 0, 1, 0, 5, 0, 0, 2'b00); tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 5, 2'b10); #2;
        chk("youngest_sel1", fwd_sel_a[3:2], 1);
        tick();
        // load-use
        drive(1, 0, 0, 0, 0, 0, 0, 2'b00); tick(); tick();
        drive(1, 0, 1, 1, 7, 0, 0, 2'b00); tick();
        drive(1, 0, 0, 0, 0, 7, 0, 2'b01); #2;
        chk("lu_stall", stall_a, 1);
        chk("lu_sel", fwd_sel_a, 0);
        tick();
        chk("lu_scnt", stall_cnt_a, 1);
        #1;
        chk("lu_after_stall", stall_a, 0);
        chk("lu_after_sel0", fwd_sel_a[1:0], 2);
        tick();
        // $0 and flushed writers never forward
        drive(1, 0, 1, 0, 0, 0, 0, 2'b00); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 2'b01); #2;
        chk("r0_sel0", fwd_sel_a[1:0], 0);
        drive(1, 1, 1, 0, 9, 0, 0, 2'b00); tick();
        drive(0, 0, 0, 0, 0, 9, 0, 2'b01); #2;
        chk("flush_sel0", fwd_sel_a[1:0], 0);
        // hold, then async reset mid-hold
        drive(1, 0, 1, 0, 4, 0, 0, 2'b00); tick();
        drive(0, 0, 0, 0, 0, 4, 0, 2'b01);
        fc = fwd_cnt_a;
        sc = stall_cnt_a;
        for (int n = 0; n < 3; n++) begin
            #2;
            chk("hold_sel0", fwd_sel_a[1:0], 1);
            chk("hold_fcnt", fwd_cnt_a, fc);
            chk("hold_scnt", stall_cnt_a, sc);
            tick();
        end
        #1 nRST = 1'b0;
        #1;
        chk("arst_sel", fwd_sel_a, 0);
        chk("arst_stall", stall_a, 0);
        chk("arst_fcnt", fwd_cnt_a, 0);
        chk("arst_scnt", stall_cnt_a, 0);
        #10 nRST = 1'b1;
        tick();
        // config B: two-stage load-use window and counter saturation
        drive(1, 0, 1, 1, 7, 7, 0, 2'b01); #2;
        chk("b_first_stall", stall_b, 0);
        tick(); #1;
        chk("b_stage0_stall", stall_b, 1);
        tick(); #1;
        chk("b_stage1_stall", stall_b, 1);
        tick(); #1;
        chk("b_stage2_stall", stall_b, 0);
        chk("b_stage2_sel0", fwd_sel_b[1:0], 3);
        repeat (36) tick();
        chk("b_scnt_sat", stall_cnt_b, 15);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), 2'($urandom));
            if ($urandom_range(0, 499) == 0) begin
                nRST = 1'b0;
                #2 nRST = 1'b1;
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
